sram_accum_host: RTL and testbench
==================================

# sram_accum_host

Host-side initiator for the SRAM float-accumulator engine. Accepts a job length N and a stream of N IEEE-754 single-precision words and writes them into the shared SRAM: header at address 0, payload at 1..N. It then starts the accumulator over the `dut_valid`/`dut_ready` handshake and waits for it to finish. Finally it reads the sum back from address N+1 and presents it on a result valid/ready port.

## Interface
- `MAX_LEN`, 65534, largest accepted N (result address N+1 must fit in 16 bits)
- `clk` input 1 — single clock, all logic rising-edge
- `reset` input 1 — synchronous, active-high
- `cmd_valid` input 1 — job request
- `cmd_len` input 16 — N, number of payload words
- `cmd_ready` output 1 — high only in IDLE
- `in_valid` input 1 — payload word valid
- `in_data` input 32 — payload float bits
- `in_ready` output 1 — high in WR_DATA while words remain
- `dut_valid` output 1 — start request to accumulator
- `dut_ready` input 1 — accumulator idle (low while busy)
- `sram_grant_dut` output 1 — SRAM mux select; 1 = accumulator owns SRAM
- `sram_write_enable` output 1; `sram_write_address` output 16; `sram_write_data` output 32
- `sram_read_address` output 16; `sram_read_data` input 32 — data valid one cycle after address
- `res_valid` output 1; `res_data` output 32; `res_err` output 1; `res_ready` input 1

## Operation
- States: IDLE → WR_HDR → WR_DATA → START → WAIT_BUSY → WAIT_DONE → RD_ADDR → RD_DATA → RESULT → IDLE.
- IDLE:
  - On `cmd_valid && cmd_ready`, latch N and go to WR_HDR.
  - If N == 0: go to RESULT with `res_data`=0x00000000, `res_err`=0. No SRAM access, no `dut_valid`.
  - If N > MAX_LEN: go to RESULT with `res_data`=0x7FC00000, `res_err`=1.
- WR_HDR: one write, address 0, data {16'h0, N}.
- WR_DATA:
  - Word count k starts at 1.
  - Each `in_valid && in_ready` writes `in_data` to address k, then increments k.
  - Leave after word N is accepted.
  - `in_ready`=0 in all other states.
- START:
  - `sram_grant_dut`=1, `dut_valid`=1.
  - Hold until `dut_valid && dut_ready` is sampled, then go to WAIT_BUSY and drop `dut_valid`.
- WAIT_BUSY: wait for `dut_ready`=0.
- WAIT_DONE: wait for `dut_ready`=1, then set `sram_grant_dut`=0.
- RD_ADDR: `sram_read_address`=N+1.
- RD_DATA: capture `sram_read_data` into `res_data`, `res_err`=0.
- RESULT: `res_valid`=1, held with data stable until `res_ready`, then IDLE.
- Address arithmetic is 16-bit unsigned; no wrap is possible because N ≤ MAX_LEN.
- `sram_write_enable` never asserts while `sram_grant_dut`=1.
- No floating-point math in this block; payload bits pass through unmodified.

## Timing
- All outputs are registered.
- Reset values: `cmd_ready`=0, `in_ready`=0, `dut_valid`=0, `sram_grant_dut`=0, `sram_write_enable`=0, both SRAM addresses=0, `sram_write_data`=0, `res_valid`=0, `res_data`=0, `res_err`=0. `cmd_ready`=1 the cycle after reset deasserts.
- Write latency: cmd handshake at cycle t → header write asserted at t+1.
- Payload word accepted at cycle c → its write appears at c+1.
- Back-to-back input: N words accepted t+1..t+N, written t+2..t+N+1; `dut_valid` first high at t+N+2.
- `in_valid` gaps stall WR_DATA with no write and no error.
- `dut_ready` falling in the same cycle as the handshake: WAIT_BUSY sees it next cycle and proceeds.
- `dut_ready` must not be treated as completion before a low has been observed.
- Completion latency: `dut_ready` rising at cycle d → `sram_read_address`=N+1 at d+1, `res_valid` at d+3.
- `res_ready` already high when `res_valid` rises: one-cycle result, `cmd_ready`=1 on the next cycle.
- Reset mid-job:
  - All outputs return to reset values at the next edge.
  - `dut_valid` and `sram_grant_dut` drop immediately.
  - SRAM contents are undefined; the accumulator shares the reset.
- `cmd_valid` outside IDLE is ignored (`cmd_ready`=0).

## Test plan
- Reset, then N=3 with payload 1.0, 2.0, 3.5 (0x3F800000, 0x40000000, 0x40600000) and back-to-back input:
  - SRAM[0]=3, SRAM[1..3] as sent.
  - `dut_valid` at t+5.
  - After completion, `res_data`=0x40D00000 (6.5), `res_err`=0.
- N=1 with `in_valid` toggling every other cycle and `res_ready` held low for 4 cycles:
  - No extra writes.
  - `res_valid` held with `res_data` stable until `res_ready`.
- N=0 → `res_valid` with 0x00000000 two cycles after cmd; no SRAM writes, `dut_valid` never high.
- N=65535 (> MAX_LEN) → `res_err`=1, `res_data`=0x7FC00000; no SRAM writes.
- Accumulator model holds `dut_ready`=0 for 2 cycles before the handshake, then stays busy 10 cycles:
  - `dut_valid` held across the stall.
  - Read of address N+1 issued only after `dut_ready` returns high.
- Assert `reset` during WR_DATA (k=2 of 5) → all outputs at reset values next cycle; a fresh N=2 job completes with a correct sum.

Source files
------------

// File: rtl/sram_accum_host_if.sv
// Command, payload, accumulator-handshake, SRAM and result signals of sram_accum_host.
// master is the host block itself; slave is its environment.
interface sram_accum_host_if;
    logic        cmd_valid;
    logic [15:0] cmd_len;
    logic        cmd_ready;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        dut_valid;
    logic        dut_ready;
    logic        sram_grant_dut;
    logic        sram_write_enable;
    logic [15:0] sram_write_address;
    logic [31:0] sram_write_data;
    logic [15:0] sram_read_address;
    logic [31:0] sram_read_data;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_err;
    logic        res_ready;

    modport master (
        input  cmd_valid, cmd_len, in_valid, in_data, dut_ready, sram_read_data, res_ready,
        output cmd_ready, in_ready, dut_valid, sram_grant_dut, sram_write_enable,
               sram_write_address, sram_write_data, sram_read_address,
               res_valid, res_data, res_err
    );

    modport slave (
        output cmd_valid, cmd_len, in_valid, in_data, dut_ready, sram_read_data, res_ready,
        input  cmd_ready, in_ready, dut_valid, sram_grant_dut, sram_write_enable,
               sram_write_address, sram_write_data, sram_read_address,
               res_valid, res_data, res_err
    );
endinterface

// File: rtl/sram_accum_host.sv
// Host initiator for the SRAM float accumulator: loads header and payload into SRAM,
// kicks the accumulator, then reads the sum back from address N+1.
module sram_accum_host #(
    parameter int unsigned MAX_LEN = 32'd65534
) (
    input logic               clk,
    input logic               reset,
    sram_accum_host_if.master bus
);

    typedef enum logic [3:0] {
        StIdle,
        StWrHdr,
        StWrData,
        StStart,
        StWaitBusy,
        StWaitDone,
        StRdAddr,
        StRdData,
        StResult
    } state_e;

    state_e      state_q;
    logic [15:0] n_q;
    logic [15:0] k_q;
    logic        cmd_len_ok;
    logic        n_zero;
    logic        n_over;

    always_comb begin
        cmd_len_ok = (bus.cmd_len != 16'd0) && (32'(bus.cmd_len) <= MAX_LEN);
        n_zero     = (n_q == 16'd0);
        n_over     = (32'(n_q) > MAX_LEN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q                <= StIdle;
            n_q                    <= '0;
            k_q                    <= '0;
            bus.cmd_ready          <= 1'b0;
            bus.in_ready           <= 1'b0;
            bus.dut_valid          <= 1'b0;
            bus.sram_grant_dut     <= 1'b0;
            bus.sram_write_enable  <= 1'b0;
            bus.sram_write_address <= '0;
            bus.sram_write_data    <= '0;
            bus.sram_read_address  <= '0;
            bus.res_valid          <= 1'b0;
            bus.res_data           <= '0;
            bus.res_err            <= 1'b0;
        end else begin
            bus.sram_write_enable <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    bus.cmd_ready <= 1'b1;
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        bus.cmd_ready <= 1'b0;
                        n_q           <= bus.cmd_len;
                        k_q           <= 16'd1;
                        state_q       <= StWrHdr;
                        // Header write and first payload slot open on the cycle after the command.
                        if (cmd_len_ok) begin
                            bus.sram_write_enable  <= 1'b1;
                            bus.sram_write_address <= '0;
                            bus.sram_write_data    <= {16'h0, bus.cmd_len};
                            bus.in_ready           <= 1'b1;
                        end
                    end
                end
                StWrHdr, StWrData: begin
                    if (n_zero || n_over) begin
                        bus.res_valid <= 1'b1;
                        bus.res_data  <= n_zero ? 32'h0000_0000 : 32'h7FC0_0000;
                        bus.res_err   <= n_over;
                        state_q       <= StResult;
                    end else if (bus.in_ready) begin
                        state_q <= StWrData;
                        if (bus.in_valid) begin
                            bus.sram_write_enable  <= 1'b1;
                            bus.sram_write_address <= k_q;
                            bus.sram_write_data    <= bus.in_data;
                            k_q                    <= k_q + 16'd1;
                            if (k_q == n_q) begin
                                bus.in_ready <= 1'b0;
                            end
                        end
                    end else begin
                        // Last payload write has landed; hand the SRAM over.
                        bus.sram_grant_dut <= 1'b1;
                        bus.dut_valid      <= 1'b1;
                        state_q            <= StStart;
                    end
                end
                StStart: begin
                    if (bus.dut_ready) begin
                        bus.dut_valid <= 1'b0;
                        state_q       <= StWaitBusy;
                    end
                end
                StWaitBusy: begin
                    if (!bus.dut_ready) begin
                        state_q <= StWaitDone;
                    end
                end
                StWaitDone: begin
                    if (bus.dut_ready) begin
                        bus.sram_grant_dut    <= 1'b0;
                        bus.sram_read_address <= n_q + 16'd1;
                        state_q               <= StRdAddr;
                    end
                end
                StRdAddr: begin
                    state_q <= StRdData;
                end
                StRdData: begin
                    bus.res_data  <= bus.sram_read_data;
                    bus.res_err   <= 1'b0;
                    bus.res_valid <= 1'b1;
                    state_q       <= StResult;
                end
                StResult: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        state_q       <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_accum_host.sv
// Directed bench for sram_accum_host with an SRAM model and a simple accumulator model
// that writes a preset sum to address N+1 after a configurable busy period.
module tb_sram_accum_host;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sram_accum_host_if bus ();

    sram_accum_host #(.MAX_LEN(32'd65534)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int wr_count = 0;
    int grant_we_count = 0;
    int dv_count = 0;

    logic [31:0] mem [0:65535];

    // Accumulator model controls and state
    int          acc_pre_stall = 0;
    int          acc_busy = 4;
    logic [31:0] acc_sum = 32'h0;
    int          acc_phase = 0;
    int          stall_left = 0;
    int          busy_left = 0;
    int          acc_done_cyc = 0;
    logic        acc_we = 1'b0;
    logic [15:0] acc_waddr = 16'h0;
    logic [31:0] acc_wdata = 32'h0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.sram_write_enable === 1'b1) begin
            mem[bus.sram_write_address] <= bus.sram_write_data;
            wr_count <= wr_count + 1;
            if (bus.sram_grant_dut === 1'b1) grant_we_count <= grant_we_count + 1;
        end
        if (acc_we) mem[acc_waddr] <= acc_wdata;
        if (bus.dut_valid === 1'b1) dv_count <= dv_count + 1;
        bus.sram_read_data <= mem[bus.sram_read_address];
    end

    initial begin : acc_model
        bus.dut_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            acc_we = 1'b0;
            if (reset === 1'b1) begin
                bus.dut_ready = 1'b1;
                acc_phase     = 0;
                stall_left    = acc_pre_stall;
            end else begin
                case (acc_phase)
                    0: begin
                        if (bus.dut_valid === 1'b1) begin
                            if (stall_left > 0) begin
                                bus.dut_ready = 1'b0;
                                stall_left--;
                            end else begin
                                bus.dut_ready = 1'b1;
                                acc_phase     = 1;
                            end
                        end else begin
                            stall_left = acc_pre_stall;
                        end
                    end
                    1: begin
                        bus.dut_ready = 1'b0;
                        busy_left     = acc_busy - 1;
                        acc_phase     = 2;
                    end
                    default: begin
                        busy_left--;
                        if (busy_left <= 0) begin
                            acc_waddr     = mem[0][15:0] + 16'd1;
                            acc_wdata     = acc_sum;
                            acc_we        = 1'b1;
                            bus.dut_ready = 1'b1;
                            acc_done_cyc  = cyc;
                            acc_phase     = 0;
                            stall_left    = acc_pre_stall;
                        end
                    end
                endcase
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [15:0] len);
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_wait: got %b want 1", bus.cmd_ready);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = len;
    endtask

    task automatic wait_res(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.res_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.cmd_ready, bus.in_ready, bus.dut_valid, bus.sram_grant_dut, bus.sram_write_enable,
             bus.res_valid, bus.res_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0", {bus.cmd_ready, bus.in_ready, bus.dut_valid,
                     bus.sram_grant_dut, bus.sram_write_enable, bus.res_valid, bus.res_err});
        end
        checks++;
        if ({bus.sram_write_address, bus.sram_read_address} !== 32'h0) begin
            errors++;
            $display("FAIL reset_addr: got %h want 0",
                     {bus.sram_write_address, bus.sram_read_address});
        end
        checks++;
        if ({bus.sram_write_data, bus.res_data} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", {bus.sram_write_data, bus.res_data});
        end
        reset = 1'b0;
        checks++;
        if (bus.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_cmd_ready_low: got %b want 0", bus.cmd_ready);
        end
        tick();
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cmd_ready_rise: got %b want 1", bus.cmd_ready);
        end
    endtask

    task automatic test_basic();
        logic [31:0] w [3];
        int          base_wr;
        bit          seen;
        w[0] = 32'h3F80_0000;
        w[1] = 32'h4000_0000;
        w[2] = 32'h4060_0000;
        acc_pre_stall = 0;
        acc_busy      = 4;
        acc_sum       = 32'h40D0_0000;
        bus.res_ready = 1'b1;
        base_wr       = wr_count;
        send_cmd(16'd3);
        bus.in_valid = 1'b1;
        bus.in_data  = w[0];
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if ({bus.sram_write_enable, bus.sram_write_address, bus.sram_write_data} !==
            {1'b1, 16'h0, 32'h3}) begin
            errors++;
            $display("FAIL basic_hdr: got %b/%h/%h want 1/0000/00000003", bus.sram_write_enable,
                     bus.sram_write_address, bus.sram_write_data);
        end
        checks++;
        if ({bus.in_ready, bus.cmd_ready} !== 2'b10) begin
            errors++;
            $display("FAIL basic_ready: got %b want 10", {bus.in_ready, bus.cmd_ready});
        end
        for (int i = 0; i < 3; i++) begin
            bus.in_data = w[i];
            tick();
            checks++;
            if ({bus.sram_write_enable, bus.sram_write_address, bus.sram_write_data} !==
                {1'b1, 16'(i + 1), w[i]}) begin
                errors++;
                $display("FAIL basic_payload%0d: got %b/%h/%h want 1/%h/%h", i,
                         bus.sram_write_enable, bus.sram_write_address, bus.sram_write_data,
                         16'(i + 1), w[i]);
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_in_ready_drop: got %b want 0", bus.in_ready);
        end
        tick();
        checks++;
        if ({bus.dut_valid, bus.sram_grant_dut, bus.sram_write_enable} !== 3'b110) begin
            errors++;
            $display("FAIL basic_start_t5: got %b want 110",
                     {bus.dut_valid, bus.sram_grant_dut, bus.sram_write_enable});
        end
        wait_res(60, seen);
        checks++;
        if (!seen || bus.res_data !== 32'h40D0_0000 || bus.res_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got valid=%b data=%h err=%b want 1/40d00000/0",
                     seen, bus.res_data, bus.res_err);
        end
        tick();
        checks++;
        if ({bus.res_valid, bus.cmd_ready} !== 2'b01) begin
            errors++;
            $display("FAIL basic_one_cycle_result: got %b want 01", {bus.res_valid, bus.cmd_ready});
        end
        checks++;
        if (mem[0] !== 32'h3 || mem[1] !== w[0] || mem[2] !== w[1] || mem[3] !== w[2]) begin
            errors++;
            $display("FAIL basic_sram: got %h %h %h %h want 00000003 %h %h %h",
                     mem[0], mem[1], mem[2], mem[3], w[0], w[1], w[2]);
        end
        checks++;
        if (wr_count - base_wr !== 4) begin
            errors++;
            $display("FAIL basic_write_count: got %0d want 4", wr_count - base_wr);
        end
    endtask

    task automatic test_gaps();
        int          base_wr;
        bit          seen;
        acc_sum       = 32'h3F80_0000;
        bus.res_ready = 1'b0;
        base_wr       = wr_count;
        send_cmd(16'd1);
        bus.in_valid = 1'b0;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        checks++;
        if ({bus.sram_write_enable, bus.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL gaps_stall: got we/in_ready %b want 01",
                     {bus.sram_write_enable, bus.in_ready});
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h3F80_0000;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.sram_write_enable, bus.sram_write_address, bus.sram_write_data, bus.in_ready} !==
            {1'b1, 16'h1, 32'h3F80_0000, 1'b0}) begin
            errors++;
            $display("FAIL gaps_word: got %b/%h/%h ready=%b want 1/0001/3f800000 ready=0",
                     bus.sram_write_enable, bus.sram_write_address, bus.sram_write_data,
                     bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEAD_BEEF;
        tick();
        bus.in_valid = 1'b0;
        wait_res(60, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL gaps_res_valid: got 0 want 1");
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h3F80_0000) begin
                errors++;
                $display("FAIL gaps_hold%0d: got %b/%h want 1/3f800000", i, bus.res_valid,
                         bus.res_data);
            end
            tick();
        end
        bus.res_ready = 1'b1;
        tick();
        checks++;
        if (bus.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL gaps_release: got %b want 0", bus.res_valid);
        end
        checks++;
        if (wr_count - base_wr !== 2 || mem[1] !== 32'h3F80_0000) begin
            errors++;
            $display("FAIL gaps_writes: got %0d writes mem1=%h want 2 3f800000",
                     wr_count - base_wr, mem[1]);
        end
    endtask

    task automatic test_short(input logic [15:0] len, input logic [31:0] exp_data,
                              input logic exp_err);
        int base_wr;
        int base_dv;
        bus.res_ready = 1'b1;
        base_wr       = wr_count;
        base_dv       = dv_count;
        send_cmd(len);
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if ({bus.res_valid, bus.sram_write_enable, bus.in_ready} !== 3'b000) begin
            errors++;
            $display("FAIL short_%h_t1: got %b want 000", len,
                     {bus.res_valid, bus.sram_write_enable, bus.in_ready});
        end
        tick();
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== exp_data || bus.res_err !== exp_err) begin
            errors++;
            $display("FAIL short_%h_result: got %b/%h/%b want 1/%h/%b", len, bus.res_valid,
                     bus.res_data, bus.res_err, exp_data, exp_err);
        end
        tick();
        checks++;
        if (bus.cmd_ready !== 1'b1 || wr_count != base_wr || dv_count != base_dv) begin
            errors++;
            $display("FAIL short_%h_side: got cmd_ready=%b writes=%0d dv=%0d want 1 0 0", len,
                     bus.cmd_ready, wr_count - base_wr, dv_count - base_dv);
        end
    endtask

    task automatic test_acc_stall();
        bit seen;
        acc_pre_stall = 2;
        acc_busy      = 10;
        acc_sum       = 32'h40A0_0000;
        bus.res_ready = 1'b1;
        send_cmd(16'd2);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h4000_0000;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        bus.in_data = 32'h4040_0000;
        tick();
        bus.in_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.dut_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_dut_valid%0d: got %b want 1", i, bus.dut_valid);
            end
            tick();
        end
        checks++;
        if (bus.dut_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_dut_valid_drop: got %b want 0", bus.dut_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.sram_read_address === 16'd3) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!seen || cyc != acc_done_cyc + 1) begin
            errors++;
            $display("FAIL stall_read_addr: got seen=%b at cycle %0d want 1 at %0d", seen, cyc,
                     acc_done_cyc + 1);
        end
        tick();
        tick();
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h40A0_0000 || cyc != acc_done_cyc + 3)
        begin
            errors++;
            $display("FAIL stall_result: got %b/%h at cycle %0d want 1/40a00000 at %0d",
                     bus.res_valid, bus.res_data, cyc, acc_done_cyc + 3);
        end
        acc_pre_stall = 0;
        tick();
    endtask

    task automatic test_reset_midjob();
        bit seen;
        acc_busy      = 3;
        acc_sum       = 32'h3FC0_0000;
        bus.res_ready = 1'b1;
        send_cmd(16'd5);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h1111_1111;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if ({bus.cmd_ready, bus.in_ready, bus.dut_valid, bus.sram_grant_dut, bus.sram_write_enable,
             bus.res_valid, bus.res_err} !== 7'b0) begin
            errors++;
            $display("FAIL midreset_flags: got %b want 0", {bus.cmd_ready, bus.in_ready,
                     bus.dut_valid, bus.sram_grant_dut, bus.sram_write_enable, bus.res_valid,
                     bus.res_err});
        end
        checks++;
        if ({bus.sram_write_address, bus.sram_read_address, bus.sram_write_data, bus.res_data} !==
            96'h0) begin
            errors++;
            $display("FAIL midreset_buses: got %h/%h/%h/%h want 0", bus.sram_write_address,
                     bus.sram_read_address, bus.sram_write_data, bus.res_data);
        end
        reset = 1'b0;
        tick();
        send_cmd(16'd2);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h3F80_0000;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        bus.in_data = 32'h3F00_0000;
        tick();
        bus.in_valid = 1'b0;
        wait_res(60, seen);
        checks++;
        if (!seen || bus.res_data !== 32'h3FC0_0000 || bus.res_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_rerun: got %b/%h/%b want 1/3fc00000/0", seen, bus.res_data,
                     bus.res_err);
        end
        checks++;
        if (mem[0] !== 32'h2 || mem[1] !== 32'h3F80_0000 || mem[2] !== 32'h3F00_0000) begin
            errors++;
            $display("FAIL midreset_sram: got %h %h %h want 00000002 3f800000 3f000000",
                     mem[0], mem[1], mem[2]);
        end
        checks++;
        if (grant_we_count != 0) begin
            errors++;
            $display("FAIL write_while_granted: got %0d want 0", grant_we_count);
        end
        tick();
    endtask

    initial begin
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = 16'h0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h0;
        bus.res_ready = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_short(16'd0, 32'h0000_0000, 1'b0);
        test_short(16'd65535, 32'h7FC0_0000, 1'b1);
        test_acc_stall();
        test_reset_midjob();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
